// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/b_req                access request, held until granted
//   a_we/b_we                  1 = write, 0 = read
//   a_addr/b_addr              word address (ADDR_W bits)
//   a_wdata/b_wdata            write data (DATA_W bits)
//   a_lock/b_lock              ask to keep ownership for the next access
//   a_gnt/b_gnt                access performed this cycle
//   a_rvalid/b_rvalid          one-cycle pulse the cycle after a granted read
//   a_rdata/b_rdata            read data captured on the granted read
//   mem_addr/mem_wdata/mem_we  memory side, memory writes on negedge clk
//   mem_rdata                  combinational memory read data
//
// Build option: define DMEM_ARB_RR_EN to break ties round-robin against
// last_owner; left undefined, port A always wins a tie.
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              a_lock,
    input  logic              b_lock,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state, other_st;
    logic [CW-1:0] burst, burst_nxt;
    logic          last_owner;
    logic          own_b, x_req, y_req, x_lock, tie_b;

`ifdef DMEM_ARB_RR_EN
    assign tie_b = ~last_owner;
`else
    assign tie_b = 1'b0;
`endif

    assign a_gnt    = (state == OWN_A) && a_req;
    assign b_gnt    = (state == OWN_B) && b_req;
    assign own_b    = (state == OWN_B);
    assign other_st = own_b ? OWN_A : OWN_B;
    assign x_req    = own_b ? b_req : a_req;
    assign y_req    = own_b ? a_req : b_req;
    assign x_lock   = own_b ? b_lock : a_lock;

    assign mem_we    = a_gnt ? a_we : (b_gnt & b_we);
    assign mem_addr  = a_gnt ? a_addr : (b_gnt ? b_addr : '0);
    assign mem_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

    // Run length including the grant happening now; restarts at 1 when the
    // granted port differs from the previous one, saturates at MAX_BURST.
    assign burst_nxt = (last_owner != own_b) ? CW'(1) :
                       (burst == MAXB) ? burst : burst + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst      <= '0;
            last_owner <= 1'b1;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt & ~a_we) a_rdata <= mem_rdata;
            if (b_gnt & ~b_we) b_rdata <= mem_rdata;
            if (a_gnt | b_gnt) begin
                burst      <= burst_nxt;
                last_owner <= b_gnt;
            end
            // A locked owner keeps the memory until its run hits MAX_BURST;
            // otherwise a waiting peer takes over, and a withdrawn owner
            // releases to the peer or to IDLE.
            if (state == IDLE)
                state <= (a_req && !(b_req && tie_b)) ? OWN_A : (b_req ? OWN_B : IDLE);
            else if (!(x_req && x_lock && burst_nxt < MAXB))
                state <= y_req ? other_st : (x_req ? state : IDLE);
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against an ownership model.
module tb_dmem_arbiter;
    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq[2], we[2], lk[2];
    logic [11:0] ad[2];
    logic [31:0] wd[2];
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;

    logic [31:0] mem[0:4095];
    logic [31:0] ref_mem[0:4095];

    int          n_chk = 0, n_pass = 0;
    int          own, last, run;
    logic        ev[2];
    logic [31:0] ed[2];
    logic [1:0]  obs;
    logic        gv[2];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(rq[0]), .b_req(rq[1]), .a_we(we[0]), .b_we(we[1]),
        .a_addr(ad[0]), .b_addr(ad[1]), .a_wdata(wd[0]), .b_wdata(wd[1]),
        .a_lock(lk[0]), .b_lock(lk[1]), .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int tie_winner();
`ifdef DMEM_ARB_RR_EN
        return 1 - last;
`else
        return 0;
`endif
    endfunction

    task automatic set_port(input int p, input logic r, input logic w, input logic [11:0] a,
                            input logic [31:0] d, input logic l);
        rq[p] = r; we[p] = w; ad[p] = a; wd[p] = d; lk[p] = l;
    endtask

    // Asserts reset mid-cycle, clears the model, releases at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 0, 0);
        own = -1; last = 1; run = 0;
        ev[0] = 0; ev[1] = 0; ed[0] = 0; ed[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1: checks this cycle against the model, then advances
    // the model to the next posedge.
    task automatic tick();
        int g;
        #3;
        g = (own >= 0 && rq[own]) ? own : -1;
        obs = {a_gnt, b_gnt};
        check("a_gnt", a_gnt, g == 0);
        check("b_gnt", b_gnt, g == 1);
        check("mem_we", mem_we, g >= 0 ? we[g] : 1'b0);
        check("mem_addr", mem_addr, g >= 0 ? ad[g] : 12'd0);
        check("mem_wdata", mem_wdata, g >= 0 ? wd[g] : 32'd0);
        check("a_rvalid", a_rvalid, ev[0]);
        check("b_rvalid", b_rvalid, ev[1]);
        check("a_rdata", a_rdata, ed[0]);
        check("b_rdata", b_rdata, ed[1]);
        gv[0] = (g == 0); gv[1] = (g == 1);
        ev[0] = 0; ev[1] = 0;
        if (g >= 0) begin
            if (we[g]) ref_mem[ad[g]] = wd[g];
            else begin
                ev[g] = 1;
                ed[g] = ref_mem[ad[g]];
            end
            run = (last == g) ? (run < MAXB ? run + 1 : run) : 1;
            last = g;
            if (!(lk[g] && run < MAXB)) own = rq[1-g] ? 1 - g : g;
        end else if (own < 0)
            own = (rq[0] && rq[1]) ? tie_winner() : rq[0] ? 0 : rq[1] ? 1 : -1;
        else
            own = rq[1-own] ? 1 - own : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        for (int p = 0; p < 2; p++) if (gv[p]) rq[p] = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (rq[0] || rq[1]); i++) step();
        if (rq[0] || rq[1]) check("drain_timeout", 1, 0);
    endtask

    initial begin
        logic [1:0] e34[5];
        int  na;
        bit  seen_b;
        e34 = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[12'h010] = 32'hDEADBEEF;
        ref_mem[12'h010] = 32'hDEADBEEF;
        do_reset();

        // single read with fixed latency
        set_port(0, 1, 0, 12'h010, 0, 0);
        tick();
        check("read_gnt_c0", obs, 2'b00);
        tick();
        check("read_gnt_c1", obs, 2'b10);
        rq[0] = 0;
        check("read_rvalid_c2", a_rvalid, 1);
        check("read_rdata_c2", a_rdata, 32'hDEADBEEF);
        tick();

        // B write then A read of the same address
        set_port(1, 1, 1, 12'h7FF, 32'h12345678, 0);
        drain();
        set_port(0, 1, 0, 12'h7FF, 0, 0);
        drain();
        check("wr_rd_rvalid", a_rvalid, 1);
        check("wr_rd_data", a_rdata, 32'h12345678);
        tick();

        // simultaneous requests, held: A then B alternating
        do_reset();
        set_port(0, 1, 0, 12'h001, 0, 0);
        set_port(1, 1, 0, 12'h002, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("alt_seq", obs, e34[i]);
        end

        // locked A burst limited to MAX_BURST while B waits
        do_reset();
        set_port(0, 1, 0, 12'h003, 0, 1);
        set_port(1, 1, 0, 12'h004, 0, 0);
        na = 0; seen_b = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs == 2'b10 && !seen_b) na++;
            if (obs == 2'b01) seen_b = 1;
        end
        check("burst_len", na, MAXB);
        check("burst_b_gnt", seen_b, 1);

        // A withdraws while owning: no grant, then IDLE
        do_reset();
        set_port(0, 1, 1, 12'h005, 32'hA5A5A5A5, 0);
        tick();
        tick();
        check("withdraw_gnt", obs, 2'b10);
        rq[0] = 0;
        tick();
        check("withdraw_none", obs, 2'b00);
        set_port(0, 1, 0, 12'h005, 0, 0);
        tick();
        check("withdraw_idle", obs, 2'b00);
        drain();
        tick();

        // reset while B owns with a read in flight
        do_reset();
        set_port(1, 1, 0, 12'h006, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_b_gnt", b_gnt, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        do_reset();
        check("rst_after_rvalid", b_rvalid, 0);
        tick();

        // randomized traffic honouring the hold-until-granted protocol
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || gv[p])
                    set_port(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 12'h7FF : 12'($urandom_range(0, 15)),
                             $urandom, $urandom_range(0, 2) == 0);
                else
                    lk[p] = $urandom_range(0, 2) == 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
